// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline control for the 5-stage core.
// Turns hazard, taken-branch, data-memory wait and halt requests into
// per-stage freeze / bubble / flush controls, and keeps saturating stall and
// flush counters plus a consecutive-stall watchdog.
module pipeline_stall_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             deadlock_err
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  // Wide enough to hold MAX_STALL itself; the counter parks there.
  localparam int CONS_W = $clog2(MAX_STALL + 1);
  localparam logic [CONS_W-1:0] CONS_MAX  = CONS_W'(MAX_STALL);
  localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(MAX_STALL - 1);

  state_t state_q, state_d;

  logic              pc_freeze_c, ifid_freeze_c, ifid_flush_c;
  logic              idex_bubble_c, exmem_freeze_c, halted_c;
  logic              stall_evt, flush_evt, clear_consec;
  logic [CONS_W-1:0] consec_q;

  // Next-state and Mealy control decode from the current state and inputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned, which would infer a latch.
    state_d        = state_q;
    pc_freeze_c    = 1'b0;
    ifid_freeze_c  = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_freeze_c = 1'b0;
    halted_c       = 1'b0;
    stall_evt      = 1'b0;
    flush_evt      = 1'b0;
    clear_consec   = 1'b0;

    unique case (state_q)
      RUN, MEMWAIT: begin
        if (!mem_ready) begin
          // Memory stall outranks everything; the whole pipe holds and the
          // consecutive-stall counter neither counts nor clears.
          pc_freeze_c    = 1'b1;
          ifid_freeze_c  = 1'b1;
          exmem_freeze_c = 1'b1;
          state_d        = MEMWAIT;
        end else begin
          // MEMWAIT with memory ready behaves exactly like a RUN cycle.
          state_d      = RUN;
          clear_consec = 1'b1;
          if (branch_taken) begin
            // The ID instruction is squashed, so any hazard on it is moot.
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            flush_evt     = 1'b1;
          end else if (hazard_detected) begin
            pc_freeze_c   = 1'b1;
            ifid_freeze_c = 1'b1;
            idex_bubble_c = 1'b1;
            stall_evt     = 1'b1;
            clear_consec  = 1'b0;
          end else if (halt_req && state_q == RUN) begin
            state_d = HALT;
          end
        end
      end

      HALT: begin
        pc_freeze_c    = 1'b1;
        ifid_freeze_c  = 1'b1;
        exmem_freeze_c = 1'b1;
        halted_c       = 1'b1;
        if (resume) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Gate the Mealy outputs with reset so they read 0 while reset is held,
  // regardless of what the upstream inputs are doing.
  // NOTE: reset is used combinationally here on purpose; it only masks
  // outputs and never feeds back into state.
  assign pc_freeze    = rst & pc_freeze_c;
  assign ifid_freeze  = rst & ifid_freeze_c;
  assign ifid_flush   = rst & ifid_flush_c;
  assign idex_bubble  = rst & idex_bubble_c;
  assign exmem_freeze = rst & exmem_freeze_c;
  assign halted       = rst & halted_c;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_evt && stall_count != {CNT_W{1'b1}}) begin
        stall_count <= stall_count + 1'b1;
      end
      if (flush_evt && flush_count != {CNT_W{1'b1}}) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  // Consecutive-stall watchdog; the error is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      consec_q     <= '0;
      deadlock_err <= 1'b0;
    end else if (stall_evt) begin
      if (consec_q != CONS_MAX) begin
        consec_q <= consec_q + 1'b1;
      end
      if (consec_q >= CONS_LAST) begin
        deadlock_err <= 1'b1;
      end
    end else if (clear_consec) begin
      consec_q <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl. Two instances share the same
// stimulus: one with default counter width and one with 4-bit counters for
// the saturation scenario.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic hazard_detected, branch_taken, mem_ready, halt_req, resume;

  logic        pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exmem_freeze, halted;
  logic [15:0] stall_count, flush_count;
  logic        deadlock_err;

  logic        s_pc_freeze, s_ifid_freeze, s_ifid_flush, s_idex_bubble, s_exmem_freeze, s_halted;
  logic [3:0]  s_stall_count, s_flush_count;
  logic        s_deadlock_err;

  int checks = 0;
  int errors = 0;

  // Expected control word: {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exmem_freeze, halted}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b110100;
  localparam logic [5:0] C_FLUSH = 6'b001100;
  localparam logic [5:0] C_MEMW  = 6'b110010;
  localparam logic [5:0] C_HALT  = 6'b110011;

  typedef struct {
    logic [5:0] ctrl;
    string      name;
  } sb_entry_t;

  sb_entry_t sb[$];

  pipeline_stall_ctrl #(.CNT_W(16), .MAX_STALL(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_freeze       (pc_freeze),
    .ifid_freeze     (ifid_freeze),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exmem_freeze    (exmem_freeze),
    .halted          (halted),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .deadlock_err    (deadlock_err)
  );

  pipeline_stall_ctrl #(.CNT_W(4), .MAX_STALL(8)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_freeze       (s_pc_freeze),
    .ifid_freeze     (s_ifid_freeze),
    .ifid_flush      (s_ifid_flush),
    .idex_bubble     (s_idex_bubble),
    .exmem_freeze    (s_exmem_freeze),
    .halted          (s_halted),
    .stall_count     (s_stall_count),
    .flush_count     (s_flush_count),
    .deadlock_err    (s_deadlock_err)
  );

  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the DUT's control outputs.
  task automatic sb_compare();
    sb_entry_t  e;
    logic [5:0] act;
    e   = sb.pop_front();
    act = {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exmem_freeze, halted};
    checks++;
    if (act !== e.ctrl) begin
      errors++;
      $display("FAIL %s: ctrl {pc,ifid_frz,ifid_fl,bub,exmem,halt} got %b expected %b",
               e.name, act, e.ctrl);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, record the expected
  // Mealy response and compare it once the outputs have settled.
  task automatic drive(input logic hz, input logic br, input logic mr,
                       input logic hr, input logic rs,
                       input logic [5:0] exp_ctrl, input string name);
    @(negedge clk);
    hazard_detected = hz;
    branch_taken    = br;
    mem_ready       = mr;
    halt_req        = hr;
    resume          = rs;
    sb.push_back('{ctrl: exp_ctrl, name: name});
    #1;
    sb_compare();
  endtask

  task automatic idle(input string name);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, name);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0 || deadlock_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_clear: stall=%0d flush=%0d dl=%b expected 0 0 0",
               stall_count, flush_count, deadlock_err);
    end
    @(negedge clk);
    rst             = 1'b1;
    hazard_detected = 1'b0;
    branch_taken    = 1'b0;
    mem_ready       = 1'b1;
    halt_req        = 1'b0;
    resume          = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    hazard_detected = 1'b1;
    branch_taken    = 1'b0;
    mem_ready       = 1'b1;
    halt_req        = 1'b0;
    resume          = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, "reset_outputs");
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0 || deadlock_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: stall=%0d flush=%0d dl=%b expected 0 0 0",
               stall_count, flush_count, deadlock_err);
    end
    @(negedge clk);
    rst             = 1'b1;
    hazard_detected = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "hazard_stall");
    end
    idle("after_hazard");
    checks++;
    if (stall_count !== 16'd3) begin
      errors++;
      $display("FAIL stall_count_3: got %0d expected 3", stall_count);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, "branch_over_hazard");
    idle("after_branch");
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd3) begin
      errors++;
      $display("FAIL branch_counts: flush=%0d stall=%0d expected 1 3", flush_count, stall_count);
    end
  endtask

  task automatic test_memwait();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_MEMW, "memwait_hold");
    end
    checks++;
    if (stall_count !== 16'd3 || flush_count !== 16'd1) begin
      errors++;
      $display("FAIL memwait_counts: stall=%0d flush=%0d expected 3 1", stall_count, flush_count);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "memwait_exit_stall");
    idle("after_memwait");
    checks++;
    if (stall_count !== 16'd4) begin
      errors++;
      $display("FAIL memwait_exit_count: got %0d expected 4", stall_count);
    end
  endtask

  task automatic test_deadlock();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "deadlock_stall");
      checks++;
      if (deadlock_err !== 1'b0) begin
        errors++;
        $display("FAIL deadlock_early: stall %0d got %b expected 0", i, deadlock_err);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle("after_deadlock");
      checks++;
      if (deadlock_err !== 1'b1) begin
        errors++;
        $display("FAIL deadlock_sticky: idle %0d got %b expected 1", i, deadlock_err);
      end
    end
    checks++;
    if (stall_count !== 16'd12) begin
      errors++;
      $display("FAIL deadlock_stall_count: got %0d expected 12", stall_count);
    end
    apply_reset();
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NONE, "resume_in_run");
    idle("resume_noop");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE, "halt_req_cycle");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_HALT, "halt_idle");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_HALT, "halt_ignores_hazard");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_HALT, "halt_ignores_req");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_HALT, "halt_ignores_branch_mem");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_HALT, "halt_idle");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_HALT, "resume_cycle");
    idle("after_resume");
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL halt_counts: stall=%0d flush=%0d expected 0 0", stall_count, flush_count);
    end
  endtask

  task automatic test_halt_dropped();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STALL, "halt_with_hazard");
    idle("halt_dropped");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEMW, "halt_with_memwait");
    idle("halt_dropped_mem");
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, "b2b_flush0");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, "b2b_flush1");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "b2b_stall");
    idle("b2b_end");
    checks++;
    if (flush_count !== 16'd2 || stall_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_counts: flush=%0d stall=%0d expected 2 2", flush_count, stall_count);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "sat_stall");
    end
    idle("sat_idle");
    checks++;
    if (s_stall_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_stall_count: got %0d expected 15", s_stall_count);
    end
    checks++;
    if (stall_count !== 16'd20) begin
      errors++;
      $display("FAIL wide_stall_count: got %0d expected 20", stall_count);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "sat_more");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_STALL, "sat_more");
    idle("sat_idle2");
    checks++;
    if (s_stall_count !== 4'd15 || s_deadlock_err !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: stall=%0d dl=%b expected 15 1", s_stall_count, s_deadlock_err);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_memwait();
    test_deadlock();
    test_halt();
    test_halt_dropped();
    test_back_to_back();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central pipeline control for the 5-stage core; the consumer of the ID-stage hazard_detected signal.
- Turns hazard, taken-branch, data-memory wait and halt requests into per-stage freeze, bubble and flush controls.
- Keeps saturating stall and flush counters and a consecutive-stall watchdog.
- Sits between the hazard detection unit / EXE branch logic / memory stage and the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count counters (saturating).
- MAX_STALL, 8, number of consecutive hazard-stall cycles that raises deadlock_err.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- hazard_detected  input  1  hazard flag from the ID stage (combinational, same cycle).
- branch_taken  input  1  EXE-stage branch resolved taken, same cycle.
- mem_ready  input  1  data memory ready; 0 means the MEM access is still in progress.
- halt_req  input  1  one-cycle request to halt the pipeline.
- resume  input  1  one-cycle request to leave halt.
- pc_freeze  output  1  hold the PC.
- ifid_freeze  output  1  hold the IF/ID register.
- ifid_flush  output  1  clear IF/ID to a NOP.
- idex_bubble  output  1  load a NOP into ID/EX (clear WB/MEM enables).
- exmem_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- halted  output  1  high while in HALT.
- stall_count  output  CNT_W  number of hazard-stall cycles, saturating.
- flush_count  output  CNT_W  number of branch flushes, saturating.
- deadlock_err  output  1  sticky watchdog error.

Behaviour:
- FSM states are RUN, MEMWAIT and HALT; the state is registered.
- Control outputs are combinational (Mealy) from the state and the current inputs, so the response happens in the same cycle.
- Reset (rst=0, asynchronous):
  - state=RUN; all counters 0; consecutive-stall counter 0; deadlock_err=0.
  - All control outputs 0 and halted=0 while in reset.
  - Reset mid-stall or mid-halt abandons the operation immediately.
- Priority inside RUN, highest first: mem_ready=0, then branch_taken, then hazard_detected, then halt_req.
- RUN, mem_ready=0:
  - pc_freeze=ifid_freeze=exmem_freeze=1; idex_bubble=0; ifid_flush=0.
  - Next state MEMWAIT; branch_taken and hazard are ignored this cycle.
- MEMWAIT:
  - Same outputs as above while mem_ready=0.
  - When mem_ready=1, outputs are evaluated as in RUN that same cycle, and the next state is RUN.
- RUN, branch_taken=1 (mem ready):
  - ifid_flush=1 and idex_bubble=1; no freeze.
  - flush_count increments; hazard_detected is ignored because the ID instruction is being squashed.
- RUN, hazard_detected=1 (no branch, mem ready):
  - pc_freeze=ifid_freeze=idex_bubble=1.
  - stall_count increments; the consecutive-stall counter increments.
- Consecutive-stall counter:
  - Clears on any RUN cycle that is not a hazard stall.
  - Holds during MEMWAIT and HALT.
  - When it reaches MAX_STALL, deadlock_err sets and stays set until reset. Stalling continues; the block does not self-recover.
- RUN, halt_req=1 with no higher-priority event:
  - Next state HALT; this cycle's outputs are normal RUN outputs.
  - A halt_req that coincides with a higher-priority event is dropped; the requester re-asserts.
- HALT:
  - pc_freeze=ifid_freeze=exmem_freeze=1; halted=1; counters hold.
  - On resume=1, next state is RUN.
  - halt_req while in HALT is ignored; resume while not in HALT is ignored.
- Counters saturate at all-ones and never wrap.
- X-free: every output is a defined value in every state.

Test Plan:
- Reset with rst=0 while hazard_detected=1 -> all outputs 0, counts 0; release reset, hazard held 3 cycles -> pc_freeze/ifid_freeze/idex_bubble high 3 cycles, stall_count=3.
- branch_taken=1 and hazard_detected=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_freeze=0, flush_count=1, stall_count unchanged.
- mem_ready=0 for 4 cycles with hazard_detected=1 -> exmem_freeze=1 and idex_bubble=0 throughout, stall_count unchanged; on mem_ready=1, hazard stall applies that cycle.
- hazard_detected held for MAX_STALL=8 cycles -> deadlock_err rises after the 8th stall cycle and stays 1 after the hazard drops; cleared only by rst=0.
- halt_req pulse -> halted=1 from the next cycle with all freezes high; 5 idle cycles; resume pulse -> back to RUN and halted=0 the next cycle; resume sent before the halt is a no-op.
- Force stall_count to near all-ones using CNT_W=4 and 20 stall cycles -> stall_count saturates at 15 and stays there.
